// File: rtl/nested_struct_pkg.sv
// rtl/nested_struct_pkg.sv - shared word layout, default field widths and transform helper
package nested_struct_pkg;

  localparam int ADDR_W_D   = 8;
  localparam int DATA_W_D   = 32;
  localparam int ID_W_D     = 16;
  localparam int CMD_W_D    = 4;
  localparam int FIFO_DEPTH = 2;

  localparam logic [ADDR_W_D-1:0] ADDR_INC_D = 8'd1;
  localparam logic [DATA_W_D-1:0] XOR_KEY_D  = 32'hDEADBEEF;
  localparam logic [ID_W_D-1:0]   ID_INC_D   = 16'd100;
  localparam logic [CMD_W_D-1:0]  CMD_MASK_D = 4'b1010;

  typedef struct packed {
    logic [ADDR_W_D-1:0] addr;
    logic [DATA_W_D-1:0] data;
    logic                valid;
  } base_struct_t;

  typedef struct packed {
    base_struct_t        base;
    logic [ID_W_D-1:0]   id;
    logic [CMD_W_D-1:0]  cmd;
    logic                ready;
  } nested_struct_t;

  typedef struct packed {
    logic           wrap;
    nested_struct_t word;
  } xform_result_t;

  // Default-width reference of the per-word transform; the top re-derives it for any widths.
  function automatic xform_result_t xform(input nested_struct_t in_word, input logic bypass);
    xform_result_t      res;
    logic [ID_W_D:0]    id_sum;
    id_sum = {1'b0, in_word.id} + {1'b0, ID_INC_D};
    if (bypass) begin
      res.word = in_word;
      res.wrap = 1'b0;
    end else begin
      res.word.base.addr  = in_word.base.addr + ADDR_INC_D;
      res.word.base.data  = in_word.base.data ^ XOR_KEY_D;
      res.word.base.valid = in_word.base.valid & in_word.ready;
      res.word.id         = id_sum[ID_W_D-1:0];
      res.word.cmd        = in_word.cmd | CMD_MASK_D;
      res.word.ready      = in_word.base.valid;
      res.wrap            = id_sum[ID_W_D];
    end
    return res;
  endfunction

endpackage

// File: rtl/nested_struct_xform_pipe_fifo.sv
// rtl/nested_struct_xform_pipe_fifo.sv - two-entry FIFO holding transformed words
module xform_fifo2
  import nested_struct_pkg::*;
#(
  parameter int WIDTH = 63
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             not_empty,
  output logic             not_full
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && (count != 2'(FIFO_DEPTH));
  assign do_pop    = pop && (count != 2'd0);
  assign rdata     = mem[rd_ptr];
  assign not_empty = (count != 2'd0);
  assign not_full  = (count != 2'(FIFO_DEPTH));

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nested_struct_xform_pipe.sv
// rtl/nested_struct_xform_pipe.sv - field transform/bypass in front of a 2-deep output FIFO
module nested_struct_xform_pipe
  import nested_struct_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter int                ID_W     = 16,
  parameter int                CMD_W    = 4,
  parameter logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(1),
  parameter logic [DATA_W-1:0] XOR_KEY  = DATA_W'(32'hDEADBEEF),
  parameter logic [ID_W-1:0]   ID_INC   = ID_W'(100),
  parameter logic [CMD_W-1:0]  CMD_MASK = CMD_W'(4'b1010),
  localparam int               W        = ADDR_W + DATA_W + 1 + ID_W + CMD_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  input  logic         mode,
  output logic         id_wrap,
  output logic [15:0]  txn_count
);

  localparam int CMD_LSB  = 1;
  localparam int ID_LSB   = CMD_LSB + CMD_W;
  localparam int VLD_BIT  = ID_LSB + ID_W;
  localparam int DATA_LSB = VLD_BIT + 1;
  localparam int ADDR_LSB = DATA_LSB + DATA_W;

  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_data;
  logic              f_valid;
  logic [ID_W-1:0]   f_id;
  logic [CMD_W-1:0]  f_cmd;
  logic              f_ready;
  logic [ID_W-1:0]   id_sum;
  logic              id_carry;
  logic [W-1:0]      xf_word;
  logic              xf_wrap;
  logic              push;
  logic              pop;
  logic [W:0]        head;

  always_comb begin
    f_addr  = in_data[ADDR_LSB +: ADDR_W];
    f_data  = in_data[DATA_LSB +: DATA_W];
    f_valid = in_data[VLD_BIT];
    f_id    = in_data[ID_LSB +: ID_W];
    f_cmd   = in_data[CMD_LSB +: CMD_W];
    f_ready = in_data[0];
    {id_carry, id_sum} = {1'b0, f_id} + {1'b0, ID_INC};
    if (mode) begin
      xf_word = in_data;
      xf_wrap = 1'b0;
    end else begin
      // The outgoing ready bit carries the incoming base.valid.
      xf_word = {f_addr + ADDR_INC, f_data ^ XOR_KEY, f_valid & f_ready,
                 id_sum, f_cmd | CMD_MASK, f_valid};
      xf_wrap = id_carry;
    end
  end

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  xform_fifo2 #(
    .WIDTH (W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .wdata     ({xf_wrap, xf_word}),
    .pop       (pop),
    .rdata     (head),
    .not_empty (out_valid),
    .not_full  (in_ready)
  );

  assign id_wrap  = head[W];
  assign out_data = head[W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      txn_count <= 16'd0;
    end else if (pop) begin
      txn_count <= txn_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_nested_struct_xform_pipe.sv
// tb/tb_nested_struct_xform_pipe.sv - scoreboard bench for nested_struct_xform_pipe
module tb_nested_struct_xform_pipe;
  import nested_struct_pkg::*;

  typedef struct packed {
    logic        m;
    logic [61:0] d;
    logic        has_exp;
    logic [62:0] exp;
  } stim_t;

  logic        clk;
  logic        rst;
  logic [61:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [61:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        mode;
  logic        id_wrap;
  logic [15:0] txn_count;

  stim_t       pending[$];
  logic [62:0] sb[$];
  int          n_checks;
  int          n_pass;
  int          n_acc;
  logic        idle_mode;

  nested_struct_xform_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .mode      (mode),
    .id_wrap   (id_wrap),
    .txn_count (txn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [61:0] rand62();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[61:0];
  endfunction

  function automatic logic [62:0] model(input logic [61:0] d, input logic m);
    nested_struct_t s;
    nested_struct_t o;
    logic [16:0]    idsum;
    s = d;
    if (m) return {1'b0, d};
    idsum          = {1'b0, s.id} + 17'd100;
    o.base.addr    = s.base.addr + 8'd1;
    o.base.data    = s.base.data ^ 32'hDEADBEEF;
    o.base.valid   = s.base.valid & s.ready;
    o.id           = idsum[15:0];
    o.cmd          = s.cmd | 4'b1010;
    o.ready        = s.base.valid;
    return {idsum[16], o};
  endfunction

  task automatic offer(input logic [61:0] d, input logic m);
    stim_t s;
    s = '{m: m, d: d, has_exp: 1'b0, exp: '0};
    pending.push_back(s);
  endtask

  task automatic offer_exp(input logic [61:0] d, input logic [62:0] e);
    stim_t s;
    s = '{m: 1'b0, d: d, has_exp: 1'b1, exp: e};
    pending.push_back(s);
  endtask

  // One clock: drive at the falling edge, settle, account handshakes, then wait a full period.
  task automatic tick();
    stim_t       s;
    logic [62:0] e;
    if (pending.size() != 0) begin
      s        = pending[0];
      in_valid = 1'b1;
      in_data  = s.d;
      mode     = s.m;
    end else begin
      in_valid = 1'b0;
      in_data  = rand62();
      mode     = idle_mode;
    end
    #1;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check_eq("spurious_out", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          check_eq("out_data", {2'b0, out_data}, {2'b0, e[61:0]});
          check_eq("id_wrap", {63'd0, id_wrap}, {63'd0, e[62]});
        end
      end
      if (in_valid && in_ready) begin
        s = pending.pop_front();
        sb.push_back(s.has_exp ? s.exp : model(s.d, s.m));
        n_acc++;
      end
    end
    @(negedge clk);
    if (rst) sb.delete();
  endtask

  task automatic do_reset();
    pending.delete();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic drain(input int bound);
    out_ready = 1'b1;
    for (int i = 0; i < bound && (sb.size() != 0 || pending.size() != 0); i++) tick();
    check_eq("drain_done", 64'(sb.size() + pending.size()), 64'd0);
  endtask

  initial begin
    nested_struct_t v;
    nested_struct_t x;
    int             acc0;
    n_checks  = 0;
    n_pass    = 0;
    n_acc     = 0;
    idle_mode = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    mode      = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    do_reset();
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_id_wrap", {63'd0, id_wrap}, 64'd0);
    check_eq("rst_txn", {48'd0, txn_count}, 64'd0);
    check_eq("rst_out_data", {2'b0, out_data}, 64'd0);

    // Directed transform vector and one-cycle latency.
    out_ready = 1'b1;
    v = '{base: '{addr: 8'h10, data: 32'h0, valid: 1'b1}, id: 16'd5, cmd: 4'b0001, ready: 1'b1};
    x = '{base: '{addr: 8'h11, data: 32'hDEADBEEF, valid: 1'b1}, id: 16'd105, cmd: 4'b1011, ready: 1'b1};
    offer_exp(v, {1'b0, x});
    tick();
    check_eq("latency_valid", {63'd0, out_valid}, 64'd1);
    tick();

    // Address and id wrap.
    v = '{base: '{addr: 8'hFF, data: 32'h12345678, valid: 1'b1}, id: 16'hFFF0, cmd: 4'b0000, ready: 1'b0};
    x = '{base: '{addr: 8'h00, data: 32'hCC99E897, valid: 1'b0}, id: 16'h0054, cmd: 4'b1010, ready: 1'b1};
    offer_exp(v, {1'b1, x});
    drain(10);

    // Bypass words.
    repeat (4) offer(rand62(), 1'b1);
    drain(20);

    // Two queued words keep their own mode while the mode input toggles.
    out_ready = 1'b0;
    offer(rand62(), 1'b0);
    offer(rand62(), 1'b1);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      idle_mode = ~idle_mode;
      tick();
    end
    drain(10);

    // Backpressure: three offered, two accepted, head held.
    do_reset();
    out_ready = 1'b0;
    acc0 = n_acc;
    offer(rand62(), 1'b0);
    offer(rand62(), 1'b1);
    offer(rand62(), 1'b0);
    repeat (3) tick();
    check_eq("bp_accepted", 64'(n_acc - acc0), 64'd2);
    check_eq("bp_in_ready", {63'd0, in_ready}, 64'd0);
    repeat (2) tick();
    check_eq("bp_hold_data", {2'b0, out_data}, {2'b0, sb[0][61:0]});
    check_eq("bp_hold_wrap", {63'd0, id_wrap}, {63'd0, sb[0][62]});
    out_ready = 1'b1;
    tick();
    tick();
    check_eq("bp_txn2", {48'd0, txn_count}, 64'd2);
    check_eq("bp_third_acc", 64'(pending.size()), 64'd0);
    drain(10);

    // Random mixed traffic with random backpressure.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 1) offer(rand62(), 1'($urandom_range(0, 1)));
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain(1000);

    // Full-rate streaming and txn_count wrap.
    do_reset();
    out_ready = 1'b1;
    acc0 = n_acc;
    for (int i = 0; i < 100; i++) begin
      offer(rand62(), 1'($urandom_range(0, 1)));
      tick();
    end
    check_eq("stream_rate", 64'(n_acc - acc0), 64'd100);
    drain(10);
    check_eq("stream_txn100", {48'd0, txn_count}, 64'd100);
    for (int i = 0; i < 65435; i++) begin
      offer(rand62(), 1'($urandom_range(0, 1)));
      tick();
    end
    drain(10);
    check_eq("txn_ffff", {48'd0, txn_count}, 64'hFFFF);
    offer(rand62(), 1'b0);
    drain(10);
    check_eq("txn_wrap0", {48'd0, txn_count}, 64'd0);

    // Reset with the FIFO full.
    out_ready = 1'b0;
    offer(rand62(), 1'b0);
    offer(rand62(), 1'b0);
    tick();
    tick();
    check_eq("full_in_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    offer(rand62(), 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pending.delete();
    check_eq("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("mid_rst_txn", {48'd0, txn_count}, 64'd0);
    repeat (3) tick();
    check_eq("post_rst_txn", {48'd0, txn_count}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
